// File: rtl/punc_mem_arbiter_if.sv
// Bundles the two requester ports and the memory port of punc_mem_arbiter.
// The slave modport is the arbiter side; the master modport is the requester/memory side.
interface punc_mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req0_valid, req1_valid;
  logic          req0_we, req1_we;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic          req0_ready, req1_ready;
  logic          req0_rvalid, req1_rvalid;
  logic [DW-1:0] req0_rdata, req1_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          owner;

  modport slave (
    input  req0_valid, req1_valid, req0_we, req1_we,
           req0_addr, req1_addr, req0_wdata, req1_wdata, mem_rdata,
    output req0_ready, req1_ready, req0_rvalid, req1_rvalid,
           req0_rdata, req1_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           busy, owner
  );

  modport master (
    output req0_valid, req1_valid, req0_we, req1_we,
           req0_addr, req1_addr, req0_wdata, req1_wdata, mem_rdata,
    input  req0_ready, req1_ready, req0_rvalid, req1_rvalid,
           req0_rdata, req1_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           busy, owner
  );
endinterface

// File: rtl/punc_mem_arbiter.sv
// Two-requester arbiter/sequencer for the single PUnC memory port (one transaction in flight).
// Define PUNC_ARB_RR_EN for round-robin conflict resolution; otherwise requester 0 has fixed priority.
module punc_mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input logic                clk,
  input logic                rst,
  punc_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_nxt;
  logic          owner_q;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          any_valid;
  logic          win1;
  logic          accept;

  assign any_valid = bus.req0_valid | bus.req1_valid;
  assign accept    = !rst && (state == IDLE) && any_valid;

`ifdef PUNC_ARB_RR_EN
  logic last_grant;

  // On a conflict the requester that did not win last time goes first.
  assign win1 = bus.req1_valid && (!bus.req0_valid || !last_grant);

  always_ff @(posedge clk) begin
    if (rst)         last_grant <= 1'b1;
    else if (accept) last_grant <= win1;
  end
`else
  assign win1 = bus.req1_valid && !bus.req0_valid;
`endif

  // NOTE: state and latched request use <= so every register samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner_q   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner_q   <= win1;
        lat_we    <= win1 ? bus.req1_we    : bus.req0_we;
        lat_addr  <= win1 ? bus.req1_addr  : bus.req0_addr;
        lat_wdata <= win1 ? bus.req1_wdata : bus.req0_wdata;
      end
    end
  end

  // NOTE: next state gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = lat_we ? IDLE : RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are gated by rst so a reset cycle can never issue or complete anything.
  always_comb begin
    bus.req0_ready  = accept && !win1;
    bus.req1_ready  = accept && win1;
    bus.mem_en      = !rst && (state == ACCESS);
    bus.mem_we      = !rst && (state == ACCESS) && lat_we;
    bus.mem_addr    = lat_addr;
    bus.mem_wdata   = lat_wdata;
    bus.req0_rvalid = !rst && (state == RESP) && !owner_q;
    bus.req1_rvalid = !rst && (state == RESP) && owner_q;
    bus.req0_rdata  = bus.req0_rvalid ? bus.mem_rdata : '0;
    bus.req1_rdata  = bus.req1_rvalid ? bus.mem_rdata : '0;
    bus.busy        = !rst && (state != IDLE);
    bus.owner       = owner_q;
  end

endmodule
